// File: rtl/vga_pkg.sv
// Shared pattern-mode codes, default geometry and the per-pixel colour function
// for the VGA test-pattern source.
package vga_pkg;

  localparam logic [2:0] MODE_BLACK   = 3'd0;
  localparam logic [2:0] MODE_BARS    = 3'd1;
  localparam logic [2:0] MODE_HGRAD   = 3'd2;
  localparam logic [2:0] MODE_VGRAD   = 3'd3;
  localparam logic [2:0] MODE_CHECKER = 3'd4;
  localparam logic [2:0] MODE_XOR     = 3'd5;
  localparam logic [2:0] MODE_SCROLL  = 3'd6;
  localparam logic [2:0] MODE_WHITE   = 3'd7;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned BAR_W_DEF = 80;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [7:0] fill8(input logic bit_v);
    return {8{bit_v}};
  endfunction

  // Raw colour before blanking; chk is the already-combined checker cell bit.
  function automatic rgb_t pattern_color(input logic [2:0] mode,
                                         input logic [2:0] bar_idx,
                                         input logic [7:0] h,
                                         input logic [7:0] v,
                                         input logic       chk,
                                         input logic [7:0] frame);
    rgb_t c;
    c = '0;
    case (mode)
      MODE_BLACK:   c = '0;
      MODE_BARS: begin
        c.r = fill8(~bar_idx[1]);
        c.g = fill8(~bar_idx[2]);
        c.b = fill8(~bar_idx[0]);
      end
      MODE_HGRAD: begin
        c.r = h;
        c.g = h;
        c.b = h;
      end
      MODE_VGRAD: begin
        c.r = v;
        c.g = 8'h00;
        c.b = ~v;
      end
      MODE_CHECKER: begin
        c.r = fill8(chk);
        c.g = fill8(chk);
        c.b = fill8(chk);
      end
      MODE_XOR: begin
        c.r = h ^ v;
        c.g = h;
        c.b = v;
      end
      MODE_SCROLL: begin
        c.r = h + frame;
        c.g = v + frame;
        c.b = frame;
      end
      MODE_WHITE: begin
        c.r = 8'hFF;
        c.g = 8'hFF;
        c.b = 8'hFF;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_bar_counter.sv
// Tracks which colour bar the current active pixel falls in; restarts every line
// while horizontal blanking is asserted.
module vga_bar_counter
  import vga_pkg::*;
#(
  parameter int unsigned BAR_W = BAR_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hblank_in,
  output logic [2:0] bar_idx
);

  localparam int unsigned PX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(BAR_W - 1);

  logic [PX_W-1:0] bar_px;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (hblank_in) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == PX_LAST) begin
      bar_px <= '0;
      // Saturate so any pixels beyond eight bars stay in the last (black) bar.
      if (bar_idx != 3'd7) begin
        bar_idx <= bar_idx + 3'd1;
      end
    end else begin
      bar_px <= bar_px + PX_W'(1);
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: frame-latched mode select, pattern mux stage and a
// blanking stage, with syncs carried through the same two flops.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_BITS    = 10,
  parameter int unsigned V_BITS    = 10,
  parameter int unsigned BAR_W     = BAR_W_DEF,
  parameter int unsigned CHK_SHIFT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode_in,
  input  logic [H_BITS-1:0] hpos,
  input  logic [V_BITS-1:0] vpos,
  input  logic              hblank_in,
  input  logic              vblank_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [7:0]        frame
);

  logic [2:0] bar_idx;
  logic       vblank_q;
  logic       vblank_rise;
  logic [2:0] mode_q;
  rgb_t       pix_d;
  rgb_t       s1_pix_q;
  logic       s1_blank_q;
  logic       s1_hsync_q;
  logic       s1_vsync_q;
  logic       chk;
  logic       unused_hi;

  // Patterns only ever look at the low byte of the position.
  assign unused_hi = ^{hpos[H_BITS-1:8], vpos[V_BITS-1:8]};

  vga_bar_counter #(
    .BAR_W(BAR_W)
  ) u_bars (
    .clk      (clk),
    .rst      (rst),
    .hblank_in(hblank_in),
    .bar_idx  (bar_idx)
  );

  assign vblank_rise = vblank_in & ~vblank_q;

  // Mode and frame count move only on the vblank rising edge, so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblank_q <= 1'b0;
      mode_q   <= MODE_BLACK;
      frame    <= 8'h00;
    end else begin
      vblank_q <= vblank_in;
      if (vblank_rise) begin
        mode_q <= mode_in;
        frame  <= frame + 8'h01;
      end
    end
  end

  assign chk = hpos[CHK_SHIFT] ^ vpos[CHK_SHIFT];

  always_comb begin
    pix_d = pattern_color(mode_q, bar_idx, hpos[7:0], vpos[7:0], chk, frame);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_pix_q   <= '0;
      s1_blank_q <= 1'b1;
      s1_hsync_q <= 1'b0;
      s1_vsync_q <= 1'b0;
    end else begin
      s1_pix_q   <= pix_d;
      s1_blank_q <= hblank_in | vblank_in;
      s1_hsync_q <= hsync_in;
      s1_vsync_q <= vsync_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r         <= 8'h00;
      g         <= 8'h00;
      b         <= 8'h00;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      r         <= s1_blank_q ? 8'h00 : s1_pix_q.r;
      g         <= s1_blank_q ? 8'h00 : s1_pix_q.g;
      b         <= s1_blank_q ? 8'h00 : s1_pix_q.b;
      hsync_out <= s1_hsync_q;
      vsync_out <= s1_vsync_q;
    end
  end

endmodule
